// File: rtl/add_err_accum_pkg.sv
// Shared types and arithmetic helpers for the approximate-adder
// error characterisation stage.
package add_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int W_DEF = 8;

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int sae_w(input int w);
    return 3 * w + 1;
  endfunction

  function automatic int sse_w(input int w);
    return 4 * w + 2;
  endfunction

  function automatic int hd_w(input int w);
    return 2 * w + 4;
  endfunction

  // Clamp to the all-ones value of a w-bit accumulator instead of wrapping.
  function automatic logic [63:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input int          w
  );
    logic [64:0] s;
    logic [63:0] mx;
    mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    s  = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, mx}) return mx;
    return s[63:0];
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/add_err_accum_if.sv
// Sample stream in, result bundle out, for the error accumulator.
interface add_err_accum_if
  import add_eval_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = cnt_w(W),
  parameter int SAE_W = sae_w(W),
  parameter int SSE_W = sse_w(W),
  parameter int HD_W  = hd_w(W)
);

  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic [W:0]       O;

  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] n_samples;
  logic [CNT_W-1:0] n_err;
  logic [SAE_W-1:0] sum_abs;
  logic [SSE_W-1:0] sum_sq;
  logic [W:0]       wce;
  logic [HD_W-1:0]  sum_hd;

  modport master (
    output in_valid,
    output in_last,
    output A,
    output B,
    output O,
    output res_ready,
    input  in_ready,
    input  res_valid,
    input  n_samples,
    input  n_err,
    input  sum_abs,
    input  sum_sq,
    input  wce,
    input  sum_hd
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  A,
    input  B,
    input  O,
    input  res_ready,
    output in_ready,
    output res_valid,
    output n_samples,
    output n_err,
    output sum_abs,
    output sum_sq,
    output wce,
    output sum_hd
  );

endinterface

// File: rtl/add_err_accum_calc.sv
// Per-sample error arithmetic: S1 exact sum / error / |e| / diff,
// S2 square and popcount. Valid bit travels with the data.
module add_err_calc
  import add_eval_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_v,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W:0]     o,
  output logic           s2_v,
  output logic [W:0]     s2_abs,
  output logic [2*W+1:0] s2_sq,
  output logic [5:0]     s2_pc
);

  localparam int SQ_W = 2 * W + 2;

  logic [W:0]          sum;
  logic signed [W+1:0] err;

  logic                s1_v;
  logic [W:0]          s1_abs;
  logic [W:0]          s1_d;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    err = $signed({1'b0, o}) - $signed({1'b0, sum});
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= in_v;
      s2_v <= s1_v;
    end
  end

  // |e| never exceeds 2^(W+1)-1, so W+1 bits hold it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_abs <= '0;
      s1_d   <= '0;
      s2_abs <= '0;
      s2_sq  <= '0;
      s2_pc  <= '0;
    end else begin
      s1_abs <= (W+1)'(err[W+1] ? -err : err);
      s1_d   <= o ^ sum;
      s2_abs <= s1_abs;
      s2_sq  <= SQ_W'(s1_abs) * SQ_W'(s1_abs);
      s2_pc  <= popcount(32'(s1_d));
    end
  end

endmodule

// File: rtl/add_err_accum.sv
// Run control FSM and saturating metric accumulators (S3) for an
// approximate adder under test.
module add_err_accum
  import add_eval_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = cnt_w(W),
  parameter int SAE_W = sae_w(W),
  parameter int SSE_W = sse_w(W),
  parameter int HD_W  = hd_w(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  add_err_accum_if.slave bus
);

  state_t           state;
  logic             in_ready_q;
  logic             res_valid_q;
  logic             drain_q;
  logic             fire;

  logic             s2_v;
  logic [W:0]       s2_abs;
  logic [2*W+1:0]   s2_sq;
  logic [5:0]       s2_pc;

  logic [CNT_W-1:0] n_samples_q;
  logic [CNT_W-1:0] n_err_q;
  logic [SAE_W-1:0] sum_abs_q;
  logic [SSE_W-1:0] sum_sq_q;
  logic [W:0]       wce_q;
  logic [HD_W-1:0]  sum_hd_q;

  // A sample coinciding with start belongs to the aborted run.
  assign fire = bus.in_valid && in_ready_q && !start;

  add_err_calc #(
    .W (W)
  ) u_calc (
    .clk    (clk),
    .rst    (rst),
    .flush  (start),
    .in_v   (fire),
    .a      (bus.A),
    .b      (bus.B),
    .o      (bus.O),
    .s2_v   (s2_v),
    .s2_abs (s2_abs),
    .s2_sq  (s2_sq),
    .s2_pc  (s2_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      drain_q     <= 1'b0;
    end else if (start) begin
      state       <= RUN;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      drain_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= IDLE;
        end
        RUN: begin
          if (fire && bus.in_last) begin
            state      <= DRAIN;
            in_ready_q <= 1'b0;
            drain_q    <= 1'b0;
          end
        end
        // Two cycles covers S2 and the S3 update of the last sample.
        DRAIN: begin
          if (drain_q) begin
            state       <= DONE;
            res_valid_q <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      n_samples_q <= '0;
      n_err_q     <= '0;
      sum_abs_q   <= '0;
      sum_sq_q    <= '0;
      wce_q       <= '0;
      sum_hd_q    <= '0;
    end else if (s2_v) begin
      n_samples_q <= CNT_W'(sat_add(64'(n_samples_q), 64'd1, CNT_W));
      n_err_q     <= CNT_W'(sat_add(64'(n_err_q),
                                    64'(s2_abs != '0), CNT_W));
      sum_abs_q   <= SAE_W'(sat_add(64'(sum_abs_q), 64'(s2_abs), SAE_W));
      sum_sq_q    <= SSE_W'(sat_add(64'(sum_sq_q), 64'(s2_sq), SSE_W));
      sum_hd_q    <= HD_W'(sat_add(64'(sum_hd_q), 64'(s2_pc), HD_W));
      if (s2_abs > wce_q) wce_q <= s2_abs;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.n_samples = n_samples_q;
  assign bus.n_err     = n_err_q;
  assign bus.sum_abs   = sum_abs_q;
  assign bus.sum_sq    = sum_sq_q;
  assign bus.wce       = wce_q;
  assign bus.sum_hd    = sum_hd_q;

endmodule

// File: doc/add_err_accum.md
Name: add_err_accum

Overview:
- Streaming error-characterisation stage that sits directly downstream of an N-bit approximate adder (N+1-bit output).
- Each cycle it consumes one operand pair (A, B) together with the approximate sum O and computes the exact sum internally.
- Over a run of samples it accumulates the adder's metrics: sample count, error-sample count, sum |e|, sum e^2, worst-case |e|, and total Hamming distance.
- Feeds the characterisation harness that reports MAE/MSE/WCE/EP/HD for each adder variant.

Parameters:
- W, 8, operand width; O is W+1 bits.
- CNT_W, 2*W+1, width of sample and error counters; covers an exhaustive 2^(2W) sweep.
- SAE_W, 3*W+1, width of the sum-of-|e| accumulator.
- SSE_W, 4*W+2, width of the sum-of-e^2 accumulator.
- HD_W, 2*W+4, width of the Hamming-distance accumulator.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; clears accumulators and begins a run
- in_valid  in  1  sample valid
- in_ready  out  1  block accepts a sample this cycle
- in_last  in  1  qualifies the final sample of the run
- A  in  W  operand A
- B  in  W  operand B
- O  in  W+1  approximate sum from the adder under test
- res_valid  out  1  results stable and valid
- res_ready  in  1  consumer acknowledges results
- n_samples  out  CNT_W  samples accepted
- n_err  out  CNT_W  samples with O != A+B
- sum_abs  out  SAE_W  sum of |e|
- sum_sq  out  SSE_W  sum of e^2
- wce  out  W+1  max |e|
- sum_hd  out  HD_W  sum of popcount(O xor (A+B))

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named rst.
- Reset: state=IDLE; in_ready=0; res_valid=0; all accumulators and outputs 0.
- FSM:
  - IDLE: start -> RUN, clearing all accumulators in the same edge.
  - RUN: in_ready=1. A sample transfers when in_valid&&in_ready. A transfer with in_last=1 -> DRAIN, and in_ready drops the next cycle.
  - DRAIN: wait until the pipeline is empty (2 cycles) -> DONE.
  - DONE: res_valid=1 and outputs held. res_ready -> IDLE with res_valid=0 the next cycle.
- start in RUN, DRAIN or DONE: aborts the run. Pipeline is flushed, accumulators cleared, state -> RUN, res_valid=0.
- Pipeline:
  - S1 registers S=A+B (W+1 bits), e=O-S (signed W+2), |e|, and d=O^S.
  - S2 registers e^2 and popcount(d).
  - S3 accumulates.
- Latency from the sample edge to accumulator update is 3 cycles; throughput is 1 sample/cycle with no bubbles.
- Per-sample arithmetic:
  - |e| max is 2^(W+1)-1.
  - n_err increments iff e!=0.
  - wce = max(wce, |e|).
- Accumulators saturate at all-ones; they never wrap.
- in_valid with in_ready=0 is ignored; no sample is lost or counted.
- in_last without in_valid has no effect.
- rst mid-run overrides everything and returns to the reset state on the next edge.
- start and rst in the same cycle: rst wins.
- An empty run cannot occur; a run ends only via in_last. start then in_last on the first sample gives n_samples=1.
- Outputs change only in S3 updates or on clear. Values are valid for sampling only while res_valid=1.

Decomposition:
- Package add_eval_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - width constants/functions derived from W: CNT_W, SAE_W, SSE_W, HD_W;
  - a saturating-add helper function;
  - a popcount function.
- Sub-module add_err_calc holds stages S1–S2: exact sum, signed error, |e|, e^2 and popcount. Its handshake-free valid bit is pipelined alongside the data.
- The top level holds the FSM and the accumulators.

Test Plan:
- Exact-adder model, exhaustive 65536 pairs, in_last on pair 65535 -> n_samples=65536, n_err=0, sum_abs=0, sum_sq=0, wce=0, sum_hd=0, res_valid high.
- Single sample A=255, B=255, O=503 -> S=510, e=-7, n_err=1, sum_abs=7, sum_sq=49, wce=7, sum_hd=popcount(503^510)=popcount(9)=2.
- Samples (3,4,O=7), (1,1,O=3), (0,0,O=1) with in_valid gaps of 2 cycles -> n_samples=3, n_err=2, sum_abs=2, sum_sq=2, wce=1, sum_hd=2.
- Assert start while in DONE without res_ready, then stream 1 sample (10,20,O=40) -> accumulators cleared first, final sum_abs=10, sum_sq=100, wce=10.
- Assert rst during RUN after 5 samples -> next cycle all outputs 0, in_ready=0, state IDLE, until a new start.
- Saturation check with W=2 override and CNT_W forced to 2: 5 samples -> n_samples=3 (saturated), no wrap to 0 or 1.
